riscv_core_dcache_axi_bridge: RTL and testbench
===============================================

Name: riscv_core_dcache_axi_bridge

Overview:
- Memory-side responder for the D-cache controller's simple request/done interface. Converts it into AXI4 master transactions.
- Read side: a line-fill request becomes one INCR burst. The returned beats are assembled into a cache line, then a one-cycle done pulse is returned.
- Write side: a write-through store becomes one single-beat AXI write, with data and strobe aligned to the byte address. The done pulse is returned on B response.
- Sits between the D-cache controller and the AXI interconnect.

Parameters:
- ADDR_WIDTH, 64, address width on both sides.
- CORE_DATA_WIDTH, 64, store data width; must equal AXI_DATA_WIDTH.
- AXI_DATA_WIDTH, 64, AXI data bus width.
- LINE_WIDTH, 256, cache line width.
- BEATS, LINE_WIDTH/AXI_DATA_WIDTH (4), beats per fill burst (derived).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_mem_read_req  in  1  level; fill request, held until done
- i_mem_read_address  in  ADDR_WIDTH  line-aligned fill address
- o_mem_read_done  out  1  one-cycle pulse; line valid
- o_mem_read_line  out  LINE_WIDTH  assembled line
- i_mem_write_valid  in  1  level; store request, held until done
- i_mem_write_data  in  CORE_DATA_WIDTH  unshifted store data
- i_mem_write_address  in  ADDR_WIDTH  byte address
- i_mem_write_strobe  in  8  unshifted size strobe (0x01/0x03/0x0F/0xFF)
- o_mem_write_done  out  1  one-cycle pulse
- o_bus_error  out  1  one-cycle pulse on non-OKAY resp or rlast mismatch
- o_araddr  out  ADDR_WIDTH; o_arlen out 8; o_arsize out 3; o_arburst out 2; o_arvalid out 1; i_arready in 1
- i_rdata  in  AXI_DATA_WIDTH; i_rresp in 2; i_rlast in 1; i_rvalid in 1; o_rready out 1
- o_awaddr  out  ADDR_WIDTH; o_awlen out 8; o_awsize out 3; o_awburst out 2; o_awvalid out 1; i_awready in 1
- o_wdata  out  AXI_DATA_WIDTH; o_wstrb out 8; o_wlast out 1; o_wvalid out 1; i_wready in 1
- i_bresp  in  2; i_bvalid in 1; o_bready out 1

Behaviour:
- Reset (i_rst_n asynchronous, active-low; clock i_clk): all valid/ready/done/error outputs are 0.
  - o_mem_read_line and all address/data/strobe registers are 0.
  - Both FSMs go to IDLE.
  - Reset mid-transaction abandons it silently; no done pulse is generated.
- Read FSM and write FSM are independent. The cache never asserts both requests at once; if it does, both proceed concurrently.
- Read FSM, R_IDLE -> R_ADDR -> R_DATA -> R_DONE -> R_IDLE:
  - R_IDLE: on i_mem_read_req=1, register the address with bits [4:0] forced to 0 and assert o_arvalid next cycle.
  - Constant AR attributes: arlen=BEATS-1 (3), arsize=3, arburst=2'b01 INCR.
  - R_ADDR: o_arvalid held until i_arready; all AR fields stable while arvalid=1; then go to R_DATA.
  - R_DATA: o_rready=1. Beat counter starts at 0; each R handshake writes i_rdata into o_mem_read_line[count*64 +: 64] and increments count.
  - Last beat is count==BEATS-1. Its handshake moves the FSM to R_DONE.
  - rlast absent on the last beat, or asserted on an earlier beat, pulses o_bus_error. The fill still ends on count.
  - Any i_rresp != 0 pulses o_bus_error; the data is still stored.
  - R_DONE: o_mem_read_done=1 for exactly one cycle (one cycle after the last R handshake), then R_IDLE.
  - o_mem_read_line holds its value until the next fill's first beat, so the cache can consume it in its following update cycle.
  - In R_IDLE the cycle after done, i_mem_read_req must be ignored for one cycle (cache drops req combinationally on done). This is implemented with the R_DONE -> R_IDLE ordering; no re-issue occurs.
- Write FSM, W_IDLE -> W_REQ -> W_RESP -> W_DONE -> W_IDLE:
  - W_IDLE: on i_mem_write_valid=1, register the following:
    - awaddr = {addr[ADDR_WIDTH-1:3], 3'b0}
    - wdata = data << (8*addr[2:0])
    - wstrb = (strobe << addr[2:0]) truncated to 8 bits
  - Constant write attributes: awlen=0, awsize=3, awburst=01, wlast=1.
  - W_REQ: o_awvalid and o_wvalid are asserted together. Each channel is tracked with a sticky accepted flag and deasserts after its own handshake; the channels may complete in either order or the same cycle.
  - When both channels are accepted, go to W_RESP.
  - W_RESP: o_bready=1; on i_bvalid go to W_DONE. i_bresp != 0 pulses o_bus_error.
  - W_DONE: o_mem_write_done=1 for one cycle, then W_IDLE.
- Latency with zero-wait slave:
  - Fill: req -> arvalid in 1 cycle; done 1 cycle after the 4th beat.
  - Store: done 1 cycle after bvalid handshake.
- Unsupported: cache must not change address/data while its request is pending (not checked).

Test Plan:
- Fill, addr 0x0000_1234: req=1 ->
  - araddr=0x1220, arlen=3, arsize=3, arburst=1.
  - Slave returns 0xA0,0xA1,0xA2,0xA3 (rlast on 4th).
  - One-cycle done; line[63:0]=0xA0, line[255:192]=0xA3; o_bus_error=0.
- Fill with arready delayed 5 cycles and rvalid gaps between beats -> AR fields stable throughout, exactly 4 stores, single done pulse, no second AR.
- Store byte: addr 0x1003, data 0x55, strobe 0x01 -> awaddr=0x1000, wdata=0x0000_0000_5500_0000, wstrb=0x08, wlast=1; done one cycle after bvalid.
- Store word: addr 0x1004, strobe 0x0F, data 0xDEADBEEF; wready 3 cycles before awready -> wstrb=0xF0, wdata=0xDEADBEEF_0000_0000, each valid drops after own handshake, single done.
- Error: rresp=2'b10 on beat 1 -> o_bus_error pulses once, fill completes, done asserted. Separately, bresp=2'b11 on a store -> o_bus_error pulse and done.
- Reset asserted during R_DATA after 2 beats -> all outputs 0 immediately; line=0; no done; a new request after release issues a fresh AR.

Source files
------------

// File: rtl/riscv_core_dcache_axi_bridge.sv
// rtl/riscv_core_dcache_axi_bridge.sv - D-cache request/done to AXI4 master bridge
// Line fills become one INCR burst; write-through stores become one aligned single-beat write.
module riscv_core_dcache_axi_bridge #(
  parameter int ADDR_WIDTH      = 64,
  parameter int CORE_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int LINE_WIDTH      = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
  output logic                       o_mem_read_done,
  output logic [LINE_WIDTH-1:0]      o_mem_read_line,
  input  logic                       i_mem_write_valid,
  input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
  input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
  input  logic [7:0]                 i_mem_write_strobe,
  output logic                       o_mem_write_done,
  output logic                       o_bus_error,
  output logic [ADDR_WIDTH-1:0]      o_araddr,
  output logic [7:0]                 o_arlen,
  output logic [2:0]                 o_arsize,
  output logic [1:0]                 o_arburst,
  output logic                       o_arvalid,
  input  logic                       i_arready,
  input  logic [AXI_DATA_WIDTH-1:0]  i_rdata,
  input  logic [1:0]                 i_rresp,
  input  logic                       i_rlast,
  input  logic                       i_rvalid,
  output logic                       o_rready,
  output logic [ADDR_WIDTH-1:0]      o_awaddr,
  output logic [7:0]                 o_awlen,
  output logic [2:0]                 o_awsize,
  output logic [1:0]                 o_awburst,
  output logic                       o_awvalid,
  input  logic                       i_awready,
  output logic [AXI_DATA_WIDTH-1:0]  o_wdata,
  output logic [7:0]                 o_wstrb,
  output logic                       o_wlast,
  output logic                       o_wvalid,
  input  logic                       i_wready,
  input  logic [1:0]                 i_bresp,
  input  logic                       i_bvalid,
  output logic                       o_bready
);
  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [CNT_W-1:0] r_count;
  logic aw_acc, w_acc;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'd3;
  assign o_arburst = 2'b01;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wlast   = 1'b1;

  logic r_hs, r_last_beat, b_hs, aw_hs, w_hs;
  assign r_hs        = i_rvalid & o_rready;
  assign r_last_beat = (r_count == CNT_W'(BEATS - 1));
  assign b_hs        = i_bvalid & o_bready;
  assign aw_hs       = o_awvalid & i_awready;
  assign w_hs        = o_wvalid & i_wready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (i_mem_read_req) r_next = R_ADDR;
      R_ADDR: if (i_arready) r_next = R_DATA;
      R_DATA: if (r_hs && r_last_beat) r_next = R_DONE;
      R_DONE: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    o_arvalid       = (r_state == R_ADDR);
    o_rready        = (r_state == R_DATA);
    o_mem_read_done = (r_state == R_DONE);
  end

  // Beats land in place, so the previous line stays readable until the next fill's first beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_araddr        <= '0;
      o_mem_read_line <= '0;
      r_count         <= '0;
    end else begin
      if (r_state == R_IDLE && i_mem_read_req) begin
        o_araddr <= i_mem_read_address & ~ADDR_WIDTH'(31);
        r_count  <= '0;
      end
      if (r_hs) begin
        for (int i = 0; i < BEATS; i++)
          if (r_count == CNT_W'(i))
            o_mem_read_line[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
        r_count <= r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (i_mem_write_valid) w_next = W_REQ;
      W_REQ:  if ((aw_acc || aw_hs) && (w_acc || w_hs)) w_next = W_RESP;
      W_RESP: if (i_bvalid) w_next = W_DONE;
      W_DONE: w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    o_awvalid        = (w_state == W_REQ) && !aw_acc;
    o_wvalid         = (w_state == W_REQ) && !w_acc;
    o_bready         = (w_state == W_RESP);
    o_mem_write_done = (w_state == W_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_awaddr <= '0;
      o_wdata  <= '0;
      o_wstrb  <= '0;
      aw_acc   <= 1'b0;
      w_acc    <= 1'b0;
    end else begin
      if (w_state == W_IDLE) begin
        aw_acc <= 1'b0;
        w_acc  <= 1'b0;
        if (i_mem_write_valid) begin
          o_awaddr <= i_mem_write_address & ~ADDR_WIDTH'(7);
          o_wdata  <= i_mem_write_data << {i_mem_write_address[2:0], 3'b000};
          o_wstrb  <= i_mem_write_strobe << i_mem_write_address[2:0];
        end
      end else begin
        if (aw_hs) aw_acc <= 1'b1;
        if (w_hs)  w_acc  <= 1'b1;
      end
    end
  end

  // Bad response or a burst whose rlast disagrees with the beat count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_bus_error <= 1'b0;
    else o_bus_error <= (r_hs && ((i_rresp != 2'b00) || (i_rlast != r_last_beat)))
                     || (b_hs && (i_bresp != 2'b00));
  end
endmodule

// File: tb/tb_riscv_core_dcache_axi_bridge.sv
// tb/tb_riscv_core_dcache_axi_bridge.sv - directed bench for the D-cache AXI bridge
module tb_riscv_core_dcache_axi_bridge;
  logic         clk, rst_n;
  logic         mem_read_req;
  logic [63:0]  mem_read_address;
  logic         mem_read_done;
  logic [255:0] mem_read_line;
  logic         mem_write_valid;
  logic [63:0]  mem_write_data, mem_write_address;
  logic [7:0]   mem_write_strobe;
  logic         mem_write_done, bus_error;
  logic [63:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen, wstrb;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0, errors = 0;
  int n_rd_done = 0, n_wr_done = 0, n_err = 0, n_ar = 0, n_rbeat = 0;
  int s_rd, s_wr, s_err, s_ar, s_rb;

  riscv_core_dcache_axi_bridge dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read_req(mem_read_req), .i_mem_read_address(mem_read_address),
    .o_mem_read_done(mem_read_done), .o_mem_read_line(mem_read_line),
    .i_mem_write_valid(mem_write_valid), .i_mem_write_data(mem_write_data),
    .i_mem_write_address(mem_write_address), .i_mem_write_strobe(mem_write_strobe),
    .o_mem_write_done(mem_write_done), .o_bus_error(bus_error),
    .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Event counters, sampled mid-cycle while inputs and outputs are settled.
  always @(negedge clk) begin
    if (mem_read_done)    n_rd_done++;
    if (mem_write_done)   n_wr_done++;
    if (bus_error)        n_err++;
    if (arvalid && arready) n_ar++;
    if (rvalid && rready) n_rbeat++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_rd = n_rd_done; s_wr = n_wr_done; s_err = n_err; s_ar = n_ar; s_rb = n_rbeat;
  endtask

  task automatic do_fill(input logic [63:0] addr, input logic [63:0] exp_araddr, input int ar_delay,
                         input int gap, input int err_beat, input int rlast_beat, input logic [63:0] base);
    logic [255:0] exp_line;
    mem_read_req = 1'b1;
    mem_read_address = addr;
    @(negedge clk);
    check("ar_valid", arvalid, 1'b1);
    check("ar_addr", araddr, exp_araddr);
    check("ar_len", arlen, 8'd3);
    check("ar_size", arsize, 3'd3);
    check("ar_burst", arburst, 2'b01);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      check("ar_hold_valid", arvalid, 1'b1);
      check("ar_hold_addr", araddr, exp_araddr);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("ar_drop", arvalid, 1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) @(negedge clk);
      check("r_ready", rready, 1'b1);
      check("rd_done_early", mem_read_done, 1'b0);
      rvalid = 1'b1;
      rdata  = base + 64'(b);
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == rlast_beat);
      exp_line[b*64 +: 64] = base + 64'(b);
      @(negedge clk);
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    end
    check("rd_done", mem_read_done, 1'b1);
    mem_read_req = 1'b0;
    @(negedge clk);
    check("rd_done_pulse", mem_read_done, 1'b0);
    check("rd_line", mem_read_line, exp_line);
    check("ar_idle", arvalid, 1'b0);
  endtask

  task automatic do_store(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int aw_delay, input int w_delay, input logic [1:0] resp,
                          input logic [63:0] exp_awaddr, input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
    int last;
    last = (aw_delay > w_delay) ? aw_delay : w_delay;
    mem_write_valid = 1'b1;
    mem_write_address = addr;
    mem_write_data = data;
    mem_write_strobe = strb;
    @(negedge clk);
    check("aw_addr", awaddr, exp_awaddr);
    check("w_data", wdata, exp_wdata);
    check("w_strb", wstrb, exp_wstrb);
    check("w_last", wlast, 1'b1);
    check("aw_attr", {awlen, awsize, awburst}, {8'd0, 3'd3, 2'b01});
    for (int c = 0; c <= last; c++) begin
      check("aw_valid", awvalid, (c <= aw_delay));
      check("w_valid", wvalid, (c <= w_delay));
      awready = (c == aw_delay);
      wready  = (c == w_delay);
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0;
    check("aw_valid_off", awvalid, 1'b0);
    check("w_valid_off", wvalid, 1'b0);
    check("b_ready", bready, 1'b1);
    check("wr_done_early", mem_write_done, 1'b0);
    bvalid = 1'b1;
    bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    check("wr_done", mem_write_done, 1'b1);
    mem_write_valid = 1'b0;
    @(negedge clk);
    check("wr_done_pulse", mem_write_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read_req = 0; mem_read_address = 0;
    mem_write_valid = 0; mem_write_data = 0; mem_write_address = 0; mem_write_strobe = 0;
    arready = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    repeat (2) @(negedge clk);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check("rst_pulses", {mem_read_done, mem_write_done, bus_error}, 3'b0);
    check("rst_line", mem_read_line, 256'd0);
    check("rst_regs", {araddr, awaddr, wdata, wstrb}, 200'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic fill
    snap();
    do_fill(64'h1234, 64'h1220, 0, 0, -1, 3, 64'hA0);
    repeat (3) @(negedge clk);
    check("f1_err", n_err - s_err, 0);
    check("f1_done_cnt", n_rd_done - s_rd, 1);
    check("f1_ar_cnt", n_ar - s_ar, 1);
    check("f1_line_lo", mem_read_line[63:0], 64'hA0);
    check("f1_line_hi", mem_read_line[255:192], 64'hA3);

    // Slow slave: delayed arready and gaps between beats
    snap();
    do_fill(64'h2_0058, 64'h2_0040, 5, 2, -1, 3, 64'h1111_0000);
    repeat (4) @(negedge clk);
    check("f2_beats", n_rbeat - s_rb, 4);
    check("f2_done_cnt", n_rd_done - s_rd, 1);
    check("f2_ar_cnt", n_ar - s_ar, 1);
    check("f2_err", n_err - s_err, 0);

    // Stores
    snap();
    do_store(64'h1003, 64'h55, 8'h01, 0, 0, 2'b00, 64'h1000, 64'h0000_0000_5500_0000, 8'h08);
    do_store(64'h1004, 64'hDEADBEEF, 8'h0F, 3, 0, 2'b00, 64'h1000, 64'hDEADBEEF_0000_0000, 8'hF0);
    repeat (2) @(negedge clk);
    check("st_done_cnt", n_wr_done - s_wr, 2);
    check("st_err", n_err - s_err, 0);

    // Read error response on beat 1
    snap();
    do_fill(64'h4000, 64'h4000, 0, 0, 1, 3, 64'hC0);
    repeat (2) @(negedge clk);
    check("rresp_err", n_err - s_err, 1);
    check("rresp_done", n_rd_done - s_rd, 1);

    // rlast early on beat 2 and missing on beat 3
    snap();
    do_fill(64'h5010, 64'h5000, 0, 0, -1, 2, 64'hE0);
    repeat (2) @(negedge clk);
    check("rlast_err", n_err - s_err, 2);
    check("rlast_done", n_rd_done - s_rd, 1);

    // Write error response
    snap();
    do_store(64'h2000, 64'h1122334455667788, 8'hFF, 1, 2, 2'b11, 64'h2000, 64'h1122334455667788, 8'hFF);
    repeat (2) @(negedge clk);
    check("bresp_err", n_err - s_err, 1);
    check("bresp_done", n_wr_done - s_wr, 1);

    // Reset in the middle of a fill
    snap();
    mem_read_req = 1'b1;
    mem_read_address = 64'h6000;
    @(negedge clk);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rdata = 64'h77 + 64'(b);
      @(negedge clk);
    end
    rvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    check("mid_rst_pulses", {mem_read_done, mem_write_done, bus_error}, 3'b0);
    check("mid_rst_line", mem_read_line, 256'd0);
    mem_read_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", n_rd_done - s_rd, 0);
    check("mid_rst_idle", arvalid, 1'b0);
    do_fill(64'h7000, 64'h7000, 0, 0, -1, 3, 64'h90);
    repeat (2) @(negedge clk);
    check("post_rst_ar", n_ar - s_ar, 2);
    check("post_rst_done", n_rd_done - s_rd, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
